gb_host_bridge: RTL and testbench
=================================

# gb_host_bridge

Host-side master for the GhostBus: converts a valid/ready request stream (address, write data, write flag) into single-cycle GhostBus write/read strobes on the `GBPORT_*` signals. It sits directly upstream of the top-level GhostBus interposer port list and drives the bus that each interposer fans out to its children. Read data is captured a fixed number of cycles after the read strobe and returned on a valid/ready response stream. One transaction is outstanding at a time.

## Interface
- `AW`, 24: GhostBus address width.
- `DW`, 32: GhostBus data width.
- `READ_LATENCY`, 2: cycles from the `GBPORT_rstb` cycle to valid `GBPORT_din`. Legal range 1..15.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  target address.
- `req_data`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DW  read data; 0 for write acks.
- `rsp_we`  out  1  1 = response is a write ack.
- `GBPORT_clk`  out  1  equals `clk` (combinational passthrough).
- `GBPORT_addr`  out  AW  bus address.
- `GBPORT_dout`  out  DW  bus write data.
- `GBPORT_din`  in  DW  bus read data.
- `GBPORT_we`  out  1  write enable, qualifies `wstb`.
- `GBPORT_wstb`  out  1  one-cycle write strobe.
- `GBPORT_rstb`  out  1  one-cycle read strobe.

## Operation
- States are IDLE, STB, RWAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `req_addr`, `req_data` and `req_we` into `GBPORT_addr`, `GBPORT_dout` and the internal write flag, then go to STB.
- **STB** (exactly one cycle)
  - Write: `GBPORT_wstb`=1 and `GBPORT_we`=1.
  - Read: `GBPORT_rstb`=1 and `GBPORT_we`=0.
  - Next state: reads go to RWAIT with counter loaded to `READ_LATENCY`. Writes go to IDLE, or to RESP when write ack is enabled.
- **RWAIT**
  - Counter decrements each cycle.
  - On the cycle the counter is 1: capture `GBPORT_din` into `rsp_data` and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data` and `rsp_we` are held stable.
  - On `rsp_ready`: go to IDLE.
- `GBPORT_addr` and `GBPORT_dout` hold their value from one accept until the next accept.
- `GBPORT_we` is 1 only during a write STB cycle.
- Strobes are never asserted outside STB.
- `rsp_data` holds its value after RESP until the next capture.

## Timing
- **Reset**
  - Outputs: `req_ready`, `rsp_valid`, `rsp_we`, `GBPORT_wstb`, `GBPORT_rstb` and `GBPORT_we` are 0; `GBPORT_addr`, `GBPORT_dout` and `rsp_data` are 0; state is IDLE.
  - `req_ready` rises in the first cycle after `rst` deasserts.
- **Read** accepted in cycle N:
  - `GBPORT_rstb` high in cycle N+1.
  - `GBPORT_din` sampled at the end of cycle N+1+`READ_LATENCY`.
  - `rsp_valid` high from cycle N+2+`READ_LATENCY`.
- **Write** accepted in cycle N: `GBPORT_wstb` high in cycle N+1; `req_ready` high again in cycle N+2 (no ack).
- **Back-pressure**
  - `rsp_valid` holds indefinitely while `rsp_ready`=0.
  - `req_ready` stays 0 from accept until the cycle after the response handshake.
  - A request is never accepted in the same cycle as a response handshake, so no same-cycle turnaround.
- **Reset mid-transaction**
  - Aborts at the next edge: strobes drop and any pending response is discarded.
  - No response is ever emitted for the aborted request.
- `READ_LATENCY`=1: RWAIT lasts one cycle, with capture at the end of cycle N+2.

## Configuration
- `GB_BRIDGE_WRITE_ACK_EN`
  - Defined: writes pass STB → RESP with `rsp_we`=1 and `rsp_data`=0. A write accepted in cycle N gives `rsp_valid` in cycle N+2, and `req_ready` returns only after that handshake.
  - Undefined: writes produce no response, and `rsp_we` is tied to 0.

## Test plan
- Reset held 3 cycles with `req_valid`=1 → no strobes and `req_ready`=0; `req_ready`=1 in the first cycle after `rst` falls.
- Write addr 0x000010, data 0xDEADBEEF (ack disabled) → `wstb`=1 and `we`=1 for exactly one cycle with addr/dout stable; `req_ready`=1 two cycles after accept; no `rsp_valid`.
- Read addr 0x000010, model returns 0xDEADBEEF with latency 2 → `rstb` one cycle; `rsp_valid` 4 cycles after accept with `rsp_data`=0xDEADBEEF and `rsp_we`=0.
- Read with `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data` stable for those 5 cycles; `req_ready` stays 0 until 1 cycle after the handshake.
- `rst` pulsed during RWAIT → no `rsp_valid`; the next read returns correct data.
- With `GB_BRIDGE_WRITE_ACK_EN`: write 0x12345678 → `rsp_valid` 2 cycles after accept with `rsp_we`=1 and `rsp_data`=0.

Source files
------------

// File: rtl/gb_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : gb_host_bridge
// Brief    : Host-side GhostBus master; turns a valid/ready request stream into
//            single-cycle write/read strobes and returns read data as a response.
//            Optional write acknowledge: define GB_BRIDGE_WRITE_ACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gb_host_bridge #(
   parameter int AW           = 24,
   parameter int DW           = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_we,
   output logic          GBPORT_clk,
   output logic [AW-1:0] GBPORT_addr,
   output logic [DW-1:0] GBPORT_dout,
   input  logic [DW-1:0] GBPORT_din,
   output logic          GBPORT_we,
   output logic          GBPORT_wstb,
   output logic          GBPORT_rstb
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_stb   = 2'd1;
   localparam logic [1:0] c_st_rwait = 2'd2;
   localparam logic [1:0] c_st_resp  = 2'd3;
   localparam logic [3:0] c_lat      = 4'(READ_LATENCY);

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_dout;
   logic          r_we;
   logic [3:0]    r_cnt;
   logic [DW-1:0] r_rsp_data;
   logic          w_accept;
   logic          w_req_ready;
   logic          w_rsp_valid;
   logic          w_rsp_we;
   logic          w_we;
   logic          w_wstb;
   logic          w_rstb;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle:  if (req_valid) w_state_next = c_st_stb;
         c_st_stb: begin
            if (!r_we) begin
               w_state_next = c_st_rwait;
            end else begin
`ifdef GB_BRIDGE_WRITE_ACK_EN
               w_state_next = c_st_resp;
`else
               w_state_next = c_st_idle;
`endif
            end
         end
         c_st_rwait: if (r_cnt == 4'd1) w_state_next = c_st_resp;
         c_st_resp:  if (rsp_ready) w_state_next = c_st_idle;
         default:    w_state_next = c_st_idle;
      endcase
   end

   // req_ready is masked by rst so nothing is offered while reset is held
   always_comb begin
      w_req_ready = (r_state == c_st_idle) && !rst;
      w_rsp_valid = (r_state == c_st_resp);
      w_wstb      = (r_state == c_st_stb) && r_we;
      w_rstb      = (r_state == c_st_stb) && !r_we;
      w_we        = (r_state == c_st_stb) && r_we;
      w_rsp_we    = 1'b0;
`ifdef GB_BRIDGE_WRITE_ACK_EN
      w_rsp_we    = (r_state == c_st_resp) && r_we;
`endif
   end

   assign w_accept = (r_state == c_st_idle) && req_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_dout     <= '0;
         r_we       <= 1'b0;
         r_cnt      <= 4'd0;
         r_rsp_data <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= req_addr;
            r_dout <= req_data;
            r_we   <= req_we;
         end
         case (r_state)
            c_st_stb: begin
               r_cnt <= c_lat;
`ifdef GB_BRIDGE_WRITE_ACK_EN
               if (r_we) r_rsp_data <= '0;
`endif
            end
            c_st_rwait: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_rsp_data <= GBPORT_din;
            end
            default: ;
         endcase
      end
   end

   assign req_ready   = w_req_ready;
   assign rsp_valid   = w_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_we      = w_rsp_we;
   assign GBPORT_clk  = clk;
   assign GBPORT_addr = r_addr;
   assign GBPORT_dout = r_dout;
   assign GBPORT_we   = w_we;
   assign GBPORT_wstb = w_wstb;
   assign GBPORT_rstb = w_rstb;

endmodule
`default_nettype wire

// File: tb/tb_gb_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_host_bridge
// Brief    : Self-checking bench for gb_host_bridge with a latency-exact bus
//            slave and a memory reference model. Honours GB_BRIDGE_WRITE_ACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_host_bridge;

   localparam int AW = 24;
   localparam int DW = 32;
   localparam int L  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_we;
   logic          gb_clk;
   logic [AW-1:0] gb_addr;
   logic [DW-1:0] gb_dout;
   logic [DW-1:0] gb_din = '0;
   logic          gb_we;
   logic          gb_wstb;
   logic          gb_rstb;

   int errors = 0;
   int checks = 0;

   gb_host_bridge #(.AW(AW), .DW(DW), .READ_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_we(rsp_we),
      .GBPORT_clk(gb_clk), .GBPORT_addr(gb_addr), .GBPORT_dout(gb_dout),
      .GBPORT_din(gb_din), .GBPORT_we(gb_we), .GBPORT_wstb(gb_wstb), .GBPORT_rstb(gb_rstb)
   );

   always #5 clk = ~clk;

   // Bus slave: memory of 16 words on addr[3:0]; read data valid only in the
   // cycle exactly L cycles after the read strobe, random noise otherwise.
   logic [DW-1:0] slv_mem [16];
   int            cyc = 0;
   int            due = -1;
   logic [3:0]    pend = 4'd0;
   int            n_wstb = 0;
   int            n_rstb = 0;

   always @(posedge clk) begin
      int cyc_old;
      cyc_old = cyc;
      cyc     = cyc + 1;
      if (gb_wstb && gb_we) begin
         slv_mem[gb_addr[3:0]] = gb_dout;
         n_wstb++;
      end
      if (gb_rstb) begin
         pend = gb_addr[3:0];
         due  = cyc_old + L;
         n_rstb++;
      end
      #1 gb_din = (cyc == due) ? slv_mem[pend] : DW'($urandom);
   end

   // Reference: what a read of each word must return
   logic [DW-1:0] ref_mem [16];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("ready_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int w0;
      wait_ready();
      w0 = n_wstb;
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_data = d;
      tick();
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
      check("wr_stb", {60'd0, gb_wstb, gb_we, gb_rstb, req_ready}, {60'd0, 4'b1100});
      check("wr_bus", {8'd0, gb_addr, gb_dout}, {8'd0, a, d});
      tick();
      check("wr_after", {61'd0, gb_wstb, gb_we, gb_rstb}, 64'd0);
      check("wr_hold", {8'd0, gb_addr, gb_dout}, {8'd0, a, d});
`ifdef GB_BRIDGE_WRITE_ACK_EN
      check("wr_ack", {29'd0, rsp_valid, rsp_we, req_ready, rsp_data}, {29'd0, 3'b110, 32'd0});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("wr_ack_done", {62'd0, rsp_valid, req_ready}, {62'd0, 2'b01});
`else
      check("wr_noack", {61'd0, rsp_valid, rsp_we, req_ready}, {61'd0, 3'b001});
`endif
      check("wr_count", 64'(n_wstb - w0), 64'd1);
      ref_mem[a[3:0]] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int stall);
      logic [DW-1:0] exp;
      int r0;
      exp = ref_mem[a[3:0]];
      wait_ready();
      r0 = n_rstb;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_data = DW'($urandom);
      tick();
      req_valid = 1'b0; req_addr = '0; req_data = '0;
      check("rd_stb", {60'd0, gb_rstb, gb_wstb, gb_we, req_ready}, {60'd0, 4'b1000});
      check("rd_addr", 64'(gb_addr), 64'(a));
      for (int i = 0; i < L; i++) begin
         tick();
         check("rd_wait", {62'd0, rsp_valid, gb_rstb}, 64'd0);
      end
      tick();
      check("rd_rsp", {30'd0, rsp_valid, rsp_we, rsp_data}, {30'd0, 2'b10, exp});
      for (int i = 0; i < stall; i++) begin
         tick();
         check("rd_stall", {30'd0, rsp_valid, req_ready, rsp_data}, {30'd0, 2'b10, exp});
      end
      rsp_ready = 1'b1;
      #1;
      check("rd_hs_ready", 64'(req_ready), 64'd0);
      tick();
      rsp_ready = 1'b0;
      check("rd_done", {30'd0, rsp_valid, req_ready, rsp_data}, {30'd0, 2'b01, exp});
      check("rd_count", 64'(n_rstb - r0), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         slv_mem[i] = 32'hA500_0000 + 32'(i);
         ref_mem[i] = 32'hA500_0000 + 32'(i);
      end

      // Reset held 3 cycles with a request pending
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000001; req_data = 32'h1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ctl", {59'd0, req_ready, rsp_valid, rsp_we, gb_wstb, gb_rstb}, 64'd0);
         check("rst_data", {8'd0, gb_addr, gb_dout}, 64'd0);
         check("rst_rsp", 64'(rsp_data), 64'd0);
      end
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
      #1;
      check("rst_release_ready", 64'(req_ready), 64'd1);
      check("rst_strobes", {62'd0, gb_wstb, gb_rstb}, 64'd0);
      check("gb_clk", 64'(gb_clk), 64'(clk));

      // Directed write then read-back
      do_write(24'h000010, 32'hDEADBEEF);
      do_read(24'h000010, 0);

      // Back-pressure: response held 5 cycles
      do_read(24'h000010, 5);
      do_read(24'h000003, 2);

      // Reset pulsed during read wait
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000005;
      tick();
      req_valid = 1'b0; req_addr = '0;
      check("abort_stb", 64'(gb_rstb), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      check("abort_rst", {61'd0, rsp_valid, req_ready, gb_rstb}, 64'd0);
      rst = 1'b0;
      #1;
      check("abort_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < L + 3; i++) begin
         tick();
         check("abort_norsp", 64'(rsp_valid), 64'd0);
      end
      do_read(24'h000005, 0);

      do_write(24'h000007, 32'h12345678);
      do_read(24'h000007, 1);

      // Random mixed traffic
      for (int i = 0; i < 25; i++) begin
         logic [AW-1:0] a;
         a = {AW{1'b0}} | AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 255)) << 4);
         if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
         else do_read(a, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
